// File: rtl/pid_incr_output.sv
// -----------------------------------------------------------------------------
// pid_incr_output
// Incremental PID output stage:
//   u(k) = u(k-1) + Kp*(ek0-ek1) + Ki*ek0 + Kd*(ek0-2*ek1+ek2)
// The three products share one signed multiplier, sequenced by a five-state
// FSM (IDLE, MUL_P, MUL_I, MUL_D, UPDATE). The ek2 history and u(k-1) are kept
// internally. The result is clamped to [U_MIN, U_MAX], and the clamped value
// becomes u(k-1) for the next sample.
//
// Ports
//   sys_clk   : system clock, rising edge
//   sys_rst   : asynchronous active-high reset
//   clear     : synchronous clear of state/history, highest priority
//   in_valid  : ek0/ek1/gains valid
//   in_ready  : block can accept a sample (IDLE only)
//   ek0, ek1  : signed current / previous error (VAL_LENGTH)
//   kp,ki,kd  : signed fixed-point gains (COEF_LENGTH, FRAC_BITS fraction)
//   u_out     : signed saturated control output
//   out_valid : one-cycle pulse, u_out updated
//   sat_hi    : last update clamped to U_MAX
//   sat_lo    : last update clamped to U_MIN
// -----------------------------------------------------------------------------
module pid_incr_output #(
    parameter int VAL_LENGTH  = 32,
    parameter int COEF_LENGTH = 16,
    parameter int FRAC_BITS   = 8,
    parameter logic signed [VAL_LENGTH-1:0] U_MAX = {1'b0, {(VAL_LENGTH-1){1'b1}}},
    parameter logic signed [VAL_LENGTH-1:0] U_MIN = {1'b1, {(VAL_LENGTH-1){1'b0}}}
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [VAL_LENGTH-1:0]  ek0,
    input  logic signed [VAL_LENGTH-1:0]  ek1,
    input  logic signed [COEF_LENGTH-1:0] kp,
    input  logic signed [COEF_LENGTH-1:0] ki,
    input  logic signed [COEF_LENGTH-1:0] kd,
    output logic signed [VAL_LENGTH-1:0]  u_out,
    output logic                          out_valid,
    output logic                          sat_hi,
    output logic                          sat_lo
);

    // Difference operands carry two guard bits; the product is widened by two
    // more bits so that three accumulated products can never overflow.
    localparam int DW  = VAL_LENGTH + 2;
    localparam int PW  = DW + COEF_LENGTH;
    localparam int ACC = VAL_LENGTH + COEF_LENGTH + 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL_P  = 3'd1,
        S_MUL_I  = 3'd2,
        S_MUL_D  = 3'd3,
        S_UPDATE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [VAL_LENGTH-1:0]  r_ek0;
    logic signed [VAL_LENGTH-1:0]  r_ek1;
    logic signed [VAL_LENGTH-1:0]  r_ek2;
    logic signed [COEF_LENGTH-1:0] r_kp;
    logic signed [COEF_LENGTH-1:0] r_ki;
    logic signed [COEF_LENGTH-1:0] r_kd;
    logic signed [ACC-1:0]         r_sum;
    logic signed [VAL_LENGTH-1:0]  r_u_out;
    logic                          r_out_valid;
    logic                          r_sat_hi;
    logic                          r_sat_lo;

    logic signed [DW-1:0]          w_ek0_x;
    logic signed [DW-1:0]          w_ek1_x;
    logic signed [DW-1:0]          w_ek2_x;
    logic signed [DW-1:0]          w_d1;
    logic signed [DW-1:0]          w_d2;
    logic signed [COEF_LENGTH-1:0] w_mul_a;
    logic signed [DW-1:0]          w_mul_b;
    logic signed [PW-1:0]          w_mul_a_x;
    logic signed [PW-1:0]          w_mul_b_x;
    logic signed [PW-1:0]          w_prod;
    logic signed [ACC-1:0]         w_prod_x;
    logic signed [ACC-1:0]         w_du;
    logic signed [ACC-1:0]         w_u_x;
    logic signed [ACC-1:0]         w_u_new;
    logic signed [ACC-1:0]         w_umax_x;
    logic signed [ACC-1:0]         w_umin_x;

    // Full-precision difference terms from the latched operands.
    assign w_ek0_x = {{2{r_ek0[VAL_LENGTH-1]}}, r_ek0};
    assign w_ek1_x = {{2{r_ek1[VAL_LENGTH-1]}}, r_ek1};
    assign w_ek2_x = {{2{r_ek2[VAL_LENGTH-1]}}, r_ek2};
    assign w_d1    = w_ek0_x - w_ek1_x;
    assign w_d2    = w_ek0_x - (w_ek1_x <<< 1) + w_ek2_x;

    // Shared multiplier operand select, driven by the current FSM state.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            S_MUL_P: begin
                w_mul_a = r_kp;
                w_mul_b = w_d1;
            end
            S_MUL_I: begin
                w_mul_a = r_ki;
                w_mul_b = w_ek0_x;
            end
            S_MUL_D: begin
                w_mul_a = r_kd;
                w_mul_b = w_d2;
            end
            default: begin
                w_mul_a = '0;
                w_mul_b = '0;
            end
        endcase
    end

    assign w_mul_a_x = {{DW{w_mul_a[COEF_LENGTH-1]}}, w_mul_a};
    assign w_mul_b_x = {{COEF_LENGTH{w_mul_b[DW-1]}}, w_mul_b};
    assign w_prod    = w_mul_a_x * w_mul_b_x;
    assign w_prod_x  = {{(ACC-PW){w_prod[PW-1]}}, w_prod};

    // Output update: floor-shift the sum, add to u(k-1), compare in ACC bits.
    assign w_du     = r_sum >>> FRAC_BITS;
    assign w_u_x    = {{(ACC-VAL_LENGTH){r_u_out[VAL_LENGTH-1]}}, r_u_out};
    assign w_u_new  = w_u_x + w_du;
    assign w_umax_x = {{(ACC-VAL_LENGTH){U_MAX[VAL_LENGTH-1]}}, U_MAX};
    assign w_umin_x = {{(ACC-VAL_LENGTH){U_MIN[VAL_LENGTH-1]}}, U_MIN};

    // FSM state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; clear overrides any state and any handshake.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        w_state_nxt = S_MUL_P;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_MUL_P:  w_state_nxt = S_MUL_I;
                S_MUL_I:  w_state_nxt = S_MUL_D;
                S_MUL_D:  w_state_nxt = S_UPDATE;
                S_UPDATE: w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM output decode.
    always_comb begin
        in_ready = 1'b0;
        if (r_state == S_IDLE) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Datapath: operand latch, product accumulation, saturated update.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ek0       <= '0;
            r_ek1       <= '0;
            r_ek2       <= '0;
            r_kp        <= '0;
            r_ki        <= '0;
            r_kd        <= '0;
            r_sum       <= '0;
            r_u_out     <= '0;
            r_out_valid <= 1'b0;
            r_sat_hi    <= 1'b0;
            r_sat_lo    <= 1'b0;
        end else if (clear) begin
            r_ek2       <= '0;
            r_sum       <= '0;
            r_u_out     <= '0;
            r_out_valid <= 1'b0;
            r_sat_hi    <= 1'b0;
            r_sat_lo    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_ek0 <= ek0;
                        r_ek1 <= ek1;
                        r_kp  <= kp;
                        r_ki  <= ki;
                        r_kd  <= kd;
                    end
                end
                S_MUL_P: r_sum <= w_prod_x;
                S_MUL_I: r_sum <= r_sum + w_prod_x;
                S_MUL_D: r_sum <= r_sum + w_prod_x;
                S_UPDATE: begin
                    r_ek2       <= r_ek1;
                    r_out_valid <= 1'b1;
                    if (w_u_new > w_umax_x) begin
                        r_u_out  <= U_MAX;
                        r_sat_hi <= 1'b1;
                        r_sat_lo <= 1'b0;
                    end else if (w_u_new < w_umin_x) begin
                        r_u_out  <= U_MIN;
                        r_sat_hi <= 1'b0;
                        r_sat_lo <= 1'b1;
                    end else begin
                        r_u_out  <= w_u_new[VAL_LENGTH-1:0];
                        r_sat_hi <= 1'b0;
                        r_sat_lo <= 1'b0;
                    end
                end
                default: r_sum <= r_sum;
            endcase
        end
    end

    assign u_out     = r_u_out;
    assign out_valid = r_out_valid;
    assign sat_hi    = r_sat_hi;
    assign sat_lo    = r_sat_lo;

endmodule

// File: tb/tb_pid_incr_output.sv
// -----------------------------------------------------------------------------
// tb_pid_incr_output
// Directed and randomized stimulus for pid_incr_output with U_MAX=100,
// U_MIN=-100. The expected output comes from a reference model that applies
// the PID increment formula with 64-bit integer arithmetic and explicit floor
// division.
// -----------------------------------------------------------------------------
module tb_pid_incr_output;

    localparam longint UMAX = 100;
    localparam longint UMIN = -100;

    logic               sys_clk;
    logic               sys_rst;
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] ek0;
    logic signed [31:0] ek1;
    logic signed [15:0] kp;
    logic signed [15:0] ki;
    logic signed [15:0] kd;
    logic signed [31:0] u_out;
    logic               out_valid;
    logic               sat_hi;
    logic               sat_lo;

    int n_tests;
    int n_fail;

    // reference model state
    longint m_u;
    longint m_ek2;
    logic   m_hi;
    logic   m_lo;

    pid_incr_output #(
        .VAL_LENGTH (32),
        .COEF_LENGTH(16),
        .FRAC_BITS  (8),
        .U_MAX      (32'sd100),
        .U_MIN      (-32'sd100)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ek0      (ek0),
        .ek1      (ek1),
        .kp       (kp),
        .ki       (ki),
        .kd       (kd),
        .u_out    (u_out),
        .out_valid(out_valid),
        .sat_hi   (sat_hi),
        .sat_lo   (sat_lo)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic void chk(input string tag, input logic signed [63:0] got,
                                input logic signed [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endfunction

    function automatic void model_reset();
        m_u   = 0;
        m_ek2 = 0;
        m_hi  = 1'b0;
        m_lo  = 1'b0;
    endfunction

    // u(k) = clamp(u(k-1) + floor((Kp*(e0-e1) + Ki*e0 + Kd*(e0-2e1+e2)) / 256))
    function automatic void model_step(input longint e0, input longint e1,
                                       input longint p, input longint i, input longint d);
        longint s;
        longint du;
        longint un;
        s  = p * (e0 - e1) + i * e0 + d * (e0 - 2 * e1 + m_ek2);
        du = s / 256;
        if ((s % 256) != 0 && s < 0) du = du - 1;
        un = m_u + du;
        if (un > UMAX) begin
            m_u = UMAX; m_hi = 1'b1; m_lo = 1'b0;
        end else if (un < UMIN) begin
            m_u = UMIN; m_hi = 1'b0; m_lo = 1'b1;
        end else begin
            m_u = un; m_hi = 1'b0; m_lo = 1'b0;
        end
        m_ek2 = e1;
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge, idle.
    task automatic send(input int e0, input int e1, input shortint p,
                        input shortint i, input shortint d);
        logic [31:0] r;
        chk("ready_idle", in_ready, 1);
        ek0 = e0; ek1 = e1; kp = p; ki = i; kd = d;
        in_valid = 1'b1;
        @(negedge sys_clk);
        // scramble inputs: only the values present at acceptance may count
        in_valid = 1'b0;
        r = $urandom; ek0 = r;
        r = $urandom; ek1 = r;
        r = $urandom; kp = r[15:0]; ki = r[31:16];
        r = $urandom; kd = r[15:0];
        model_step(longint'(e0), longint'(e1), longint'(p), longint'(i), longint'(d));
        for (int k = 0; k < 4; k++) begin
            chk("ready_busy", in_ready, 0);
            chk("ov_early", out_valid, 0);
            @(negedge sys_clk);
        end
        chk("ov_pulse", out_valid, 1);
        chk("u_out", u_out, m_u);
        chk("sat_hi", sat_hi, m_hi);
        chk("sat_lo", sat_lo, m_lo);
        @(negedge sys_clk);
        chk("ov_single", out_valid, 0);
        chk("u_hold", u_out, m_u);
        chk("sat_hi_hold", sat_hi, m_hi);
        chk("sat_lo_hold", sat_lo, m_lo);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge sys_clk);
        clear = 1'b0;
        model_reset();
        chk("clr_u", u_out, 0);
        chk("clr_hi", sat_hi, 0);
        chk("clr_lo", sat_lo, 0);
        chk("clr_rdy", in_ready, 1);
    endtask

    initial begin
        logic [31:0] r;
        logic        hit;
        int          e0;
        int          e1;
        shortint     gp;
        shortint     gi;
        shortint     gd;

        n_tests = 0;
        n_fail  = 0;
        sys_rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        ek0 = '0; ek1 = '0; kp = '0; ki = '0; kd = '0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        chk("rst_u", u_out, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_hi", sat_hi, 0);
        chk("rst_lo", sat_lo, 0);
        chk("rst_rdy", in_ready, 1);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // proportional step
        send(10, 4, 256, 0, 0);
        chk("plan_p6", u_out, 6);
        send(10, 10, 256, 0, 0);
        chk("plan_p6_hold", u_out, 6);

        // floor rounding of the integral term
        do_clear();
        send(3, 3, 0, 128, 0);
        chk("plan_floor_pos", u_out, 1);
        send(-3, -3, 0, 128, 0);
        chk("plan_floor_neg", u_out, -1);

        // derivative history
        do_clear();
        send(1, 0, 0, 0, 256);
        chk("plan_d1", u_out, 1);
        send(5, 2, 0, 0, 256);
        chk("plan_d2", u_out, 2);
        send(5, 5, 0, 0, 256);
        chk("plan_d3", u_out, -1);

        // saturation both ways
        do_clear();
        send(95, 0, 256, 0, 0);
        send(20, 0, 256, 0, 0);
        chk("plan_sat_hi_u", u_out, 100);
        chk("plan_sat_hi", sat_hi, 1);
        send(-300, 0, 256, 0, 0);
        chk("plan_sat_lo_u", u_out, -100);
        chk("plan_sat_lo", sat_lo, 1);
        chk("plan_sat_hi_off", sat_hi, 0);

        // handshake: in_valid held high, one acceptance every 5 cycles
        do_clear();
        ek0 = 1; ek1 = 0; kp = 256; ki = 0; kd = 0;
        in_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge sys_clk);
            if (c == 20) in_valid = 1'b0;
            hit = ((c % 5) == 0);
            if (hit) model_step(1, 0, 256, 0, 0);
            chk("hs_ready", in_ready, hit);
            chk("hs_ov", out_valid, hit);
            if (hit) chk("hs_u", u_out, m_u);
        end
        @(negedge sys_clk);
        chk("hs_final_u", u_out, 4);
        chk("hs_final_ov", out_valid, 0);

        // clear during MUL_I discards the sample and the ek2 history
        do_clear();
        send(3, 2, 0, 0, 256);
        ek0 = 7; ek1 = 1; kd = 256; kp = 0; ki = 0;
        in_valid = 1'b1;
        @(negedge sys_clk);
        in_valid = 1'b0;
        @(negedge sys_clk);
        clear = 1'b1;
        @(negedge sys_clk);
        clear = 1'b0;
        model_reset();
        chk("abort_clr_u", u_out, 0);
        chk("abort_clr_rdy", in_ready, 1);
        for (int k = 0; k < 5; k++) begin
            chk("abort_clr_ov", out_valid, 0);
            @(negedge sys_clk);
        end
        send(4, 1, 0, 0, 256);
        chk("abort_clr_ek2", u_out, 2);

        // a sample presented together with clear is not accepted
        ek0 = 50; ek1 = 0; kp = 256; ki = 0; kd = 0;
        clear = 1'b1; in_valid = 1'b1;
        @(negedge sys_clk);
        clear = 1'b0; in_valid = 1'b0;
        model_reset();
        chk("clr_valid_rdy", in_ready, 1);
        for (int k = 0; k < 5; k++) begin
            chk("clr_valid_ov", out_valid, 0);
            @(negedge sys_clk);
        end
        chk("clr_valid_u", u_out, 0);

        // asynchronous reset during MUL_I
        send(3, 2, 0, 0, 256);
        ek0 = 7; ek1 = 1; kd = 256;
        in_valid = 1'b1;
        @(negedge sys_clk);
        in_valid = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        chk("abort_rst_u", u_out, 0);
        chk("abort_rst_rdy", in_ready, 1);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            chk("abort_rst_ov", out_valid, 0);
            @(negedge sys_clk);
        end
        send(4, 1, 0, 0, 256);
        chk("abort_rst_ek2", u_out, 2);

        // randomized samples: small and full-range errors and gains
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) do_clear();
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom; e0 = r;
                r = $urandom; e1 = r;
            end else begin
                e0 = $urandom_range(0, 600) - 300;
                e1 = $urandom_range(0, 600) - 300;
            end
            if ($urandom_range(0, 1) == 0) begin
                r = $urandom; gp = r[15:0]; gi = r[31:16];
                r = $urandom; gd = r[15:0];
            end else begin
                gp = shortint'($urandom_range(0, 1024)) - 16'sd512;
                gi = shortint'($urandom_range(0, 1024)) - 16'sd512;
                gd = shortint'($urandom_range(0, 1024)) - 16'sd512;
            end
            send(e0, e1, gp, gi, gd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pid_incr_output.md
Name: pid_incr_output

Overview:
- Downstream consumer of the PID error stage. Takes the current/previous error pair (ek0, ek1) and Kp/Ki/Kd gains.
- Computes the incremental PID control output u(k) = u(k-1) + Kp*(ek0-ek1) + Ki*ek0 + Kd*(ek0-2*ek1+ek2).
- One shared signed multiplier, sequenced by a small FSM. ek2 history and u(k-1) are held internally.
- Output is saturated to [U_MIN, U_MAX] and drives the actuator/PWM side.

Parameters:
- VAL_LENGTH, 32, width of error inputs and control output (signed).
- COEF_LENGTH, 16, width of Kp/Ki/Kd (signed fixed-point).
- FRAC_BITS, 8, fractional bits of the gains.
- U_MAX, 2^(VAL_LENGTH-1)-1, upper output clamp.
- U_MIN, -2^(VAL_LENGTH-1), lower output clamp (U_MIN < U_MAX).

Ports:
- sys_clk, in, 1, system clock, rising edge.
- sys_rst, in, 1, asynchronous active-high reset.
- clear, in, 1, synchronous clear of state and history.
- in_valid, in, 1, ek0/ek1/gains valid.
- in_ready, out, 1, block can accept a sample.
- ek0, in, VAL_LENGTH, signed current error.
- ek1, in, VAL_LENGTH, signed previous error.
- kp, in, COEF_LENGTH, signed proportional gain.
- ki, in, COEF_LENGTH, signed integral gain.
- kd, in, COEF_LENGTH, signed derivative gain.
- u_out, out, VAL_LENGTH, signed saturated control output u(k).
- out_valid, out, 1, one-cycle pulse: u_out updated.
- sat_hi, out, 1, last update clamped to U_MAX.
- sat_lo, out, 1, last update clamped to U_MIN.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (sys_clk, sys_rst). On sys_rst all of the following go to 0: u_out, out_valid, sat_hi, sat_lo, ek2 history, latched operands and product accumulator. FSM goes to IDLE; in_ready=1 after reset.
- FSM states: IDLE, MUL_P, MUL_I, MUL_D, UPDATE.
  - IDLE: in_ready=1. On in_valid&in_ready at edge E0, latch ek0, ek1, kp, ki, kd and go to MUL_P.
  - MUL_P: sum <= sext(kp*(ek0-ek1)). Go to MUL_I.
  - MUL_I: sum <= sum + sext(ki*ek0). Go to MUL_D.
  - MUL_D: sum <= sum + sext(kd*(ek0-2*ek1+ek2)). Go to UPDATE.
  - UPDATE: form u_out, sat_hi, sat_lo (see arithmetic); ek2 <= latched ek1; out_valid=1 next cycle; return to IDLE.
- Latency: acceptance at E0 -> u_out and out_valid valid after edge E4. Throughput is one sample per 5 cycles.
- in_ready=0 in MUL_P..UPDATE. in_valid is ignored while in_ready=0; there is no buffering.
- out_valid is high exactly one cycle. A new sample may be accepted in that same cycle, since the FSM is back in IDLE.
- Arithmetic:
  - Difference terms are full precision: ek0-ek1 is VAL_LENGTH+1 bits; ek0-2*ek1+ek2 is VAL_LENGTH+2 bits.
  - Products are sign-extended into an accumulator of ACC = VAL_LENGTH+COEF_LENGTH+4 bits. The accumulator must never overflow.
  - du = sum >>> FRAC_BITS (arithmetic shift, floor toward -inf).
  - u_new = u_out + du, computed in ACC bits.
  - If u_new > U_MAX: u_out=U_MAX, sat_hi=1. If u_new < U_MIN: u_out=U_MIN, sat_lo=1. Otherwise u_out=u_new and both flags=0.
  - Saturated value becomes u(k-1) for the next sample (anti-windup by clamping).
- Flags: sat_hi/sat_lo update only in UPDATE and hold between updates.
- clear: synchronous, priority over in_valid and over any FSM state.
  - Zeroes u_out, ek2, sum, sat_hi, sat_lo and out_valid; forces FSM to IDLE. An in-flight computation is discarded.
  - A sample presented with clear is not accepted.
- sys_rst mid-computation: immediate abort to the reset state; no out_valid pulse.
- Gains and errors are sampled only at acceptance. Input changes during MUL_* have no effect.

Test Plan:
- Reset, then FRAC_BITS=8, kp=256, ki=0, kd=0, ek0=10, ek1=4 -> out_valid pulse 5 edges after acceptance, u_out=6. Repeat with ek0=ek1=10 -> u_out stays 6.
- Floor rounding: kp=0, ki=128, kd=0, ek0=ek1=3 from u=0 -> u_out=1. Then ek0=ek1=-3 -> du=floor(-1.5)=-2, u_out=-1.
- Derivative history: kd=256, kp=ki=0. Sample1 ek0=1, ek1=0 -> u=1, ek2 becomes 0. Sample2 ek0=5, ek1=2 -> term = 5-4+0 = 1, u=2. Sample3 ek0=5, ek1=5 -> term = 5-10+2 = -3, u=-1.
- Saturation: U_MAX=100, U_MIN=-100, kp=256. Drive u to 95, then ek0=20, ek1=0 -> u_out=100, sat_hi=1. Then ek0=-300, ek1=0 -> u_out=-100, sat_lo=1, sat_hi=0.
- Handshake: hold in_valid high continuously -> in_ready low for 4 cycles after each acceptance, accepts exactly every 5 cycles, one out_valid per accepted sample, back-to-back acceptance in the out_valid cycle.
- Abort: assert clear (then separately sys_rst) during MUL_I -> no out_valid, u_out=0, in_ready=1 next cycle. Next sample computes with ek2=0.
